// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue between instr_ROM and the decoder
// Runs fetch ahead of execution; a flush redirects fetch and discards buffered entries.
module fetch_queue #(
    parameter int D     = 12,
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [D-1:0]               rom_addr,
    input  logic [W-1:0]               rom_data,
    input  logic                       flush,
    input  logic [D-1:0]               flush_target,
    input  logic                       deq,
    output logic                       valid,
    output logic [W-1:0]               head_code,
    output logic [D-1:0]               head_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       at_end
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [D-1:0]  fetch_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [W-1:0]  code_mem [DEPTH];
    logic [D-1:0]  pc_mem   [DEPTH];
    logic          deq_ok;
    logic          enq_ok;
    logic          last_pc;

    assign deq_ok   = deq && (count != '0);
    // A full queue still accepts a push when the head leaves on the same edge.
    assign enq_ok   = !at_end && ((count < CW'(DEPTH)) || deq_ok);
    assign last_pc  = (fetch_pc == '1);
    assign rom_addr = fetch_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            at_end   <= 1'b0;
        end else if (flush) begin
            fetch_pc <= flush_target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            at_end   <= 1'b0;
        end else begin
            if (enq_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                // The top of the address space is the last fetch; no wrap back to 0.
                if (last_pc) begin
                    at_end <= 1'b1;
                end else begin
                    fetch_pc <= fetch_pc + 1'b1;
                end
            end
            if (deq_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq_ok, deq_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && enq_ok) begin
            code_mem[wr_ptr] <= rom_data;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

    assign valid     = (count != '0);
    assign head_code = valid ? code_mem[rd_ptr] : '0;
    assign head_pc   = valid ? pc_mem[rd_ptr]   : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        count <= CW'(DEPTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        (count == '0) |=> (count <= CW'(1)));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - vector table plus queue scoreboard for fetch_queue
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] rom_addr;
    logic [8:0]  rom_data;
    logic        flush = 1'b0;
    logic [11:0] flush_target = '0;
    logic        deq = 1'b0;
    logic        valid;
    logic [8:0]  head_code;
    logic [11:0] head_pc;
    logic [2:0]  count;
    logic        at_end;

    fetch_queue #(.D(12), .W(9), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .flush(flush), .flush_target(flush_target), .deq(deq), .valid(valid),
        .head_code(head_code), .head_pc(head_pc), .count(count), .at_end(at_end)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] rom(input logic [11:0] a);
        logic [11:0] s;
        s = a + 12'h010;
        return s[8:0];
    endfunction

    assign rom_data = rom(rom_addr);

    typedef struct {
        logic [8:0]  code;
        logic [11:0] pc;
    } ent_t;

    typedef struct {
        logic        f;
        logic [11:0] t;
        logic        d;
        int          e_count;
        logic [11:0] e_pc;
        logic [11:0] e_addr;
        logic        e_end;
    } vec_t;

    ent_t        sb[$];
    vec_t        tbl[$];
    logic [11:0] m_pc = '0;
    logic        m_end = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_pc  = '0;
        m_end = 1'b0;
    endtask

    task automatic model_edge(input logic f, input logic [11:0] t, input logic d);
        logic d_ok, e_ok;
        if (f) begin
            sb.delete();
            m_pc  = t;
            m_end = 1'b0;
        end else begin
            d_ok = d && (sb.size() != 0);
            e_ok = !m_end && ((sb.size() < 4) || d_ok);
            if (d_ok) void'(sb.pop_front());
            if (e_ok) begin
                sb.push_back('{code: rom(m_pc), pc: m_pc});
                if (m_pc == 12'hFFF) m_end = 1'b1;
                else m_pc = m_pc + 12'h001;
            end
        end
    endtask

    task automatic check_model();
        ent_t h;
        h = '{code: '0, pc: '0};
        if (sb.size() != 0) h = sb[0];
        chk("sb_count", int'(count), sb.size());
        chk("sb_valid", int'(valid), int'(sb.size() != 0));
        chk("sb_head_code", int'(head_code), int'(h.code));
        chk("sb_head_pc", int'(head_pc), int'(h.pc));
        chk("sb_rom_addr", int'(rom_addr), int'(m_pc));
        chk("sb_at_end", int'(at_end), int'(m_end));
    endtask

    task automatic step(input logic f, input logic [11:0] t, input logic d);
        flush        = f;
        flush_target = t;
        deq          = d;
        model_edge(f, t, d);
        @(posedge clk);
        #1;
        flush = 1'b0;
        deq   = 1'b0;
        check_model();
    endtask

    task automatic add(input logic f, input logic [11:0] t, input logic d, input int c,
                       input logic [11:0] p, input logic [11:0] a, input logic e);
        tbl.push_back('{f: f, t: t, d: d, e_count: c, e_pc: p, e_addr: a, e_end: e});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // fill from reset, no deq
        add(0, 12'h000, 0, 1, 12'h000, 12'h001, 0);
        add(0, 12'h000, 0, 2, 12'h000, 12'h002, 0);
        add(0, 12'h000, 0, 3, 12'h000, 12'h003, 0);
        add(0, 12'h000, 0, 4, 12'h000, 12'h004, 0);
        add(0, 12'h000, 0, 4, 12'h000, 12'h004, 0);
        // full, pop and push together
        add(0, 12'h000, 1, 4, 12'h001, 12'h005, 0);
        add(0, 12'h000, 1, 4, 12'h002, 12'h006, 0);
        add(0, 12'h000, 1, 4, 12'h003, 12'h007, 0);
        // flush with deq at count 3
        add(1, 12'h100, 0, 0, 12'h000, 12'h100, 0);
        add(0, 12'h000, 0, 1, 12'h100, 12'h101, 0);
        add(0, 12'h000, 0, 2, 12'h100, 12'h102, 0);
        add(0, 12'h000, 0, 3, 12'h100, 12'h103, 0);
        add(1, 12'h123, 1, 0, 12'h000, 12'h123, 0);
        add(0, 12'h000, 0, 1, 12'h123, 12'h124, 0);
        // end of address space
        add(1, 12'hFFE, 0, 0, 12'h000, 12'hFFE, 0);
        add(0, 12'h000, 0, 1, 12'hFFE, 12'hFFF, 0);
        add(0, 12'h000, 0, 2, 12'hFFE, 12'hFFF, 1);
        add(0, 12'h000, 0, 2, 12'hFFE, 12'hFFF, 1);
        // drain, then deq on empty
        add(0, 12'h000, 1, 1, 12'hFFF, 12'hFFF, 1);
        add(0, 12'h000, 1, 0, 12'h000, 12'hFFF, 1);
        add(0, 12'h000, 1, 0, 12'h000, 12'hFFF, 1);
        add(1, 12'h000, 0, 0, 12'h000, 12'h000, 0);
        add(0, 12'h000, 0, 1, 12'h000, 12'h001, 0);
        add(0, 12'h000, 0, 2, 12'h000, 12'h002, 0);
        add(0, 12'h000, 0, 3, 12'h000, 12'h003, 0);

        model_reset();
        #2;
        check_model();
        chk("reset_head_pc", int'(head_pc), 0);
        #10;
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].f, tbl[i].t, tbl[i].d);
            chk($sformatf("v%0d_count", i), int'(count), tbl[i].e_count);
            chk($sformatf("v%0d_head_pc", i), int'(head_pc), int'(tbl[i].e_pc));
            chk($sformatf("v%0d_rom_addr", i), int'(rom_addr), int'(tbl[i].e_addr));
            chk($sformatf("v%0d_at_end", i), int'(at_end), int'(tbl[i].e_end));
            if (i == 3) chk("fill_head_code", int'(head_code), 9'h010);
            if (i == 20) chk("empty_deq_rd_ptr", int'(dut.rd_ptr), 2);
        end

        // async reset between edges with count=3
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_count", int'(count), 0);
        chk("async_valid", int'(valid), 0);
        check_model();
        #2;
        reset = 1'b1;
        step(0, 12'h000, 0);
        chk("restart_head_pc", int'(head_pc), 0);
        chk("restart_count", int'(count), 1);

        // random traffic against the scoreboard
        for (int k = 0; k < 200; k++) begin
            step(($urandom_range(0, 15) == 0), 12'($urandom_range(12'hFF8, 12'hFFF)),
                 $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
